// File: rtl/axi_llc_cfg_seq_if.sv
// rtl/axi_llc_cfg_seq_if.sv - LLC register-bus config port (request/response) interface
interface axi_llc_cfg_seq_if;
    logic [31:0] conf_req_addr;
    logic        conf_req_write;
    logic [31:0] conf_req_wdata;
    logic [3:0]  conf_req_wstrb;
    logic        conf_req_valid;
    logic [31:0] conf_resp_rdata;
    logic        conf_resp_error;
    logic        conf_resp_ready;

    modport master (
        output conf_req_addr, conf_req_write, conf_req_wdata, conf_req_wstrb, conf_req_valid,
        input  conf_resp_rdata, conf_resp_error, conf_resp_ready
    );

    modport slave (
        input  conf_req_addr, conf_req_write, conf_req_wdata, conf_req_wstrb, conf_req_valid,
        output conf_resp_rdata, conf_resp_error, conf_resp_ready
    );
endinterface

// File: rtl/axi_llc_cfg_seq.sv
// rtl/axi_llc_cfg_seq.sv - LLC SPM/flush configuration sequencer; optional poll timeout via AXI_LLC_CFG_SEQ_TIMEOUT_EN
module axi_llc_cfg_seq #(
    parameter int unsigned SetAssociativity = 8,
    parameter logic [31:0] RegBaseAddr      = 32'h0,
    parameter logic [31:0] SpmOffset        = 32'h00,
    parameter logic [31:0] FlushOffset      = 32'h08,
    parameter logic [31:0] CommitOffset     = 32'h10,
    parameter logic [31:0] FlushedOffset    = 32'h18,
    parameter int unsigned PollGap          = 4,
    parameter int unsigned TimeoutCycles    = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [SetAssociativity-1:0] spm_mask_i,
    input  logic [SetAssociativity-1:0] flush_mask_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    axi_llc_cfg_seq_if.master           conf
);
    localparam int unsigned SA  = SetAssociativity;
    localparam int unsigned GW  = $clog2(PollGap + 1);
    localparam int unsigned TW  = $clog2(TimeoutCycles + 1);

    if (SA < 1 || SA > 32) begin : g_bad_sa
        $error("SetAssociativity out of range");
    end
    if (PollGap < 1 || TimeoutCycles < 1) begin : g_bad_gap
        $error("PollGap and TimeoutCycles must be at least 1");
    end

    typedef enum logic [3:0] {
        IDLE, WR_SPM, CMT0, WR_FL, CMT1, RD_POLL, GAP, DONE, ERR
    } state_e;

    state_e        state_q, state_d;
    state_e        tgt_q, tgt_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [SA-1:0] spm_q, spm_d;
    logic [SA-1:0] flush_q, flush_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          cpl, match, tmo_hit;

`ifdef AXI_LLC_CFG_SEQ_TIMEOUT_EN
    logic [TW-1:0] tmo_q, tmo_d;
    assign tmo_hit = (tmo_q == TW'(TimeoutCycles));
`else
    assign tmo_hit = 1'b0;
`endif

    assign cpl   = valid_q & conf.conf_resp_ready;
    assign match = ((conf.conf_resp_rdata & 32'(flush_q)) == 32'(flush_q));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            tgt_q   <= IDLE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            spm_q   <= '0;
            flush_q <= '0;
            gap_q   <= '0;
`ifdef AXI_LLC_CFG_SEQ_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            spm_q   <= spm_d;
            flush_q <= flush_d;
            gap_q   <= gap_d;
`ifdef AXI_LLC_CFG_SEQ_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    // A completed request idles one cycle (valid low, tgt_q holds the successor)
    // before the next state is entered; poll misses go straight to GAP instead.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        valid_d = valid_q;
        err_d   = err_q;
        spm_d   = spm_q;
        flush_d = flush_q;
        gap_d   = gap_q;
`ifdef AXI_LLC_CFG_SEQ_TIMEOUT_EN
        tmo_d   = tmo_q;
        if ((state_q == RD_POLL || state_q == GAP) && !tmo_hit) begin
            tmo_d = tmo_q + TW'(1);
        end
`endif
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = WR_SPM;
                    valid_d = 1'b1;
                    spm_d   = spm_mask_i;
                    flush_d = flush_mask_i;
                    err_d   = 1'b0;
                end
            end
            WR_SPM, CMT0, WR_FL, CMT1, RD_POLL: begin
                if (valid_q) begin
                    if (cpl) begin
                        valid_d = 1'b0;
                        if (conf.conf_resp_error) begin
                            state_d = ERR;
                            err_d   = 1'b1;
                        end else begin
                            unique case (state_q)
                                WR_SPM:  tgt_d = CMT0;
                                CMT0:    tgt_d = (flush_q == '0) ? DONE : WR_FL;
                                WR_FL:   tgt_d = CMT1;
                                CMT1:    tgt_d = RD_POLL;
                                default: begin
                                    if (match) begin
                                        tgt_d = DONE;
                                    end else if (tmo_hit) begin
                                        state_d = ERR;
                                        err_d   = 1'b1;
                                    end else begin
                                        state_d = GAP;
                                        gap_d   = '0;
                                    end
                                end
                            endcase
                        end
                    end
                end else begin
                    state_d = tgt_q;
                    valid_d = (tgt_q != DONE);
`ifdef AXI_LLC_CFG_SEQ_TIMEOUT_EN
                    if (state_q == CMT1) begin
                        tmo_d = '0;
                    end
`endif
                end
            end
            GAP: begin
                if (tmo_hit) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else if (gap_q == GW'(PollGap - 1)) begin
                    gap_d   = '0;
                    state_d = RD_POLL;
                    valid_d = 1'b1;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        conf.conf_req_addr  = 32'h0;
        conf.conf_req_write = 1'b0;
        conf.conf_req_wdata = 32'h0;
        conf.conf_req_wstrb = 4'h0;
        unique case (state_q)
            WR_SPM: begin
                conf.conf_req_addr  = RegBaseAddr + SpmOffset;
                conf.conf_req_write = 1'b1;
                conf.conf_req_wdata = 32'(spm_q);
                conf.conf_req_wstrb = 4'hF;
            end
            WR_FL: begin
                conf.conf_req_addr  = RegBaseAddr + FlushOffset;
                conf.conf_req_write = 1'b1;
                conf.conf_req_wdata = 32'(flush_q);
                conf.conf_req_wstrb = 4'hF;
            end
            CMT0, CMT1: begin
                conf.conf_req_addr  = RegBaseAddr + CommitOffset;
                conf.conf_req_write = 1'b1;
                conf.conf_req_wdata = 32'h1;
                conf.conf_req_wstrb = 4'hF;
            end
            RD_POLL: conf.conf_req_addr = RegBaseAddr + FlushedOffset;
            default: ;
        endcase
    end

    assign conf.conf_req_valid = valid_q;
    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);
    assign err_o  = err_q;
endmodule
